// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control sequencer: opcodes, T-state encoding
// and control-word bit positions used by the sequencer, the datapath and the bench.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } tstate_e;

  localparam int CW_W          = 16;
  localparam int CW_PC_INC     = 0;
  localparam int CW_PC_OE      = 1;
  localparam int CW_PC_LOAD    = 2;
  localparam int CW_MAR_LOAD   = 3;
  localparam int CW_RAM_OE     = 4;
  localparam int CW_RAM_WE     = 5;
  localparam int CW_IR_LOAD    = 6;
  localparam int CW_IR_OE      = 7;
  localparam int CW_A_LOAD     = 8;
  localparam int CW_A_OE       = 9;
  localparam int CW_B_LOAD     = 10;
  localparam int CW_ALU_OE     = 11;
  localparam int CW_ALU_SUB    = 12;
  localparam int CW_OUT_LOAD   = 13;
  localparam int CW_HLT        = 14;
  localparam int CW_INSTR_DONE = 15;

  // Final T-state that does useful work for each opcode; unknown opcodes act as NOP.
  function automatic tstate_e last_state(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA: return T5;
      OP_ADD, OP_SUB: return T6;
      default:        return T4;
    endcase
  endfunction

endpackage

// File: rtl/sap_control_sequencer_if.sv
// Control-word bundle between the sequencer (master) and the datapath (slave).
interface sap_control_sequencer_if #(parameter int OPC_W = 4);
  logic             run;
  logic [OPC_W-1:0] opcode;
  logic [2:0]       tstate;
  logic pc_inc, pc_oe, pc_load, mar_load, ram_oe, ram_we, ir_load, ir_oe;
  logic a_load, a_oe, b_load, alu_oe, alu_sub, out_load, hlt, instr_done;

  modport master (
    input  run, opcode,
    output tstate, pc_inc, pc_oe, pc_load, mar_load, ram_oe, ram_we, ir_load, ir_oe,
           a_load, a_oe, b_load, alu_oe, alu_sub, out_load, hlt, instr_done
  );

  modport slave (
    output run, opcode,
    input  tstate, pc_inc, pc_oe, pc_load, mar_load, ram_oe, ram_we, ir_load, ir_oe,
           a_load, a_oe, b_load, alu_oe, alu_sub, out_load, hlt, instr_done
  );
endinterface

// File: rtl/sap_ring_counter.sv
// T-state register with run hold, early return to T1 and the halt latch.
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic    CLK,
  input  logic    RESET,
  input  logic    run,
  input  logic    end_now,
  input  logic    halt_now,
  output tstate_e tstate,
  output logic    halted
);

  tstate_e state_q, state_n;
  logic    halted_q, halted_n;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= T1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      halted_q <= halted_n;
    end
  end

  // Once halted, the state stays parked at T4 regardless of run.
  always_comb begin
    state_n  = state_q;
    halted_n = halted_q;
    if (!halted_q && run) begin
      if (halt_now) begin
        halted_n = 1'b1;
      end else if (end_now) begin
        state_n = T1;
      end else begin
        case (state_q)
          T1:      state_n = T2;
          T2:      state_n = T3;
          T3:      state_n = T4;
          T4:      state_n = T5;
          T5:      state_n = T6;
          default: state_n = T1;
        endcase
      end
    end
  end

  assign tstate = state_q;
  assign halted = halted_q;

endmodule

// File: rtl/sap_control_sequencer.sv
// Control sequencer for the 8-bit bus computer: fetch/execute decode of the
// current T-state and IR opcode into the per-cycle control word.
module sap_control_sequencer
  import sap_pkg::*;
#(
  parameter bit EARLY_END = 1'b1,
  parameter int OPC_W     = 4
) (
  input logic CLK,
  input logic RESET,
  sap_control_sequencer_if.master bus
);

  logic [3:0]      op;
  tstate_e         tstate;
  logic            halted;
  logic            end_now;
  logic            halt_now;
  logic [CW_W-1:0] cw;

  assign op       = bus.opcode[OPC_W-1 -: 4];
  assign end_now  = EARLY_END ? (tstate == last_state(op)) : (tstate == T6);
  assign halt_now = (tstate == T4) && (op == OP_HLT);

  sap_ring_counter u_ring (
    .CLK      (CLK),
    .RESET    (RESET),
    .run      (bus.run),
    .end_now  (end_now),
    .halt_now (halt_now),
    .tstate   (tstate),
    .halted   (halted)
  );

  // Controls are live only when running and not halted; hlt itself reflects the latch.
  always_comb begin
    cw = '0;
    if (!RESET && !halted && bus.run) begin
      case (tstate)
        T1: begin cw[CW_PC_OE] = 1'b1; cw[CW_MAR_LOAD] = 1'b1; end
        T2: cw[CW_PC_INC] = 1'b1;
        T3: begin cw[CW_RAM_OE] = 1'b1; cw[CW_IR_LOAD] = 1'b1; end
        default: begin
          case (op)
            OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
              if (tstate == T4) begin
                cw[CW_IR_OE]    = 1'b1;
                cw[CW_MAR_LOAD] = 1'b1;
              end else if (tstate == T5) begin
                if (op == OP_STA) begin
                  cw[CW_A_OE]   = 1'b1;
                  cw[CW_RAM_WE] = 1'b1;
                end else begin
                  cw[CW_RAM_OE] = 1'b1;
                  cw[CW_A_LOAD] = (op == OP_LDA);
                  cw[CW_B_LOAD] = (op != OP_LDA);
                end
              end else if (op == OP_ADD || op == OP_SUB) begin
                cw[CW_ALU_OE] = 1'b1;
                cw[CW_A_LOAD] = 1'b1;
              end
              cw[CW_ALU_SUB] = (op == OP_SUB) && (tstate != T4);
            end
            OP_LDI: if (tstate == T4) begin cw[CW_IR_OE] = 1'b1; cw[CW_A_LOAD]   = 1'b1; end
            OP_JMP: if (tstate == T4) begin cw[CW_IR_OE] = 1'b1; cw[CW_PC_LOAD]  = 1'b1; end
            OP_OUT: if (tstate == T4) begin cw[CW_A_OE]  = 1'b1; cw[CW_OUT_LOAD] = 1'b1; end
            default: ;
          endcase
        end
      endcase
      cw[CW_INSTR_DONE] = end_now && (op != OP_HLT);
    end
    cw[CW_HLT] = halted;
  end

  assign bus.tstate     = tstate;
  assign bus.pc_inc     = cw[CW_PC_INC];
  assign bus.pc_oe      = cw[CW_PC_OE];
  assign bus.pc_load    = cw[CW_PC_LOAD];
  assign bus.mar_load   = cw[CW_MAR_LOAD];
  assign bus.ram_oe     = cw[CW_RAM_OE];
  assign bus.ram_we     = cw[CW_RAM_WE];
  assign bus.ir_load    = cw[CW_IR_LOAD];
  assign bus.ir_oe      = cw[CW_IR_OE];
  assign bus.a_load     = cw[CW_A_LOAD];
  assign bus.a_oe       = cw[CW_A_OE];
  assign bus.b_load     = cw[CW_B_LOAD];
  assign bus.alu_oe     = cw[CW_ALU_OE];
  assign bus.alu_sub    = cw[CW_ALU_SUB];
  assign bus.out_load   = cw[CW_OUT_LOAD];
  assign bus.hlt        = cw[CW_HLT];
  assign bus.instr_done = cw[CW_INSTR_DONE];

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer: one early-end and one fixed-length instance.
module tb_sap_control_sequencer;
  import sap_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  sap_control_sequencer_if #(.OPC_W(4)) bus_e ();
  sap_control_sequencer_if #(.OPC_W(4)) bus_f ();

  sap_control_sequencer #(.EARLY_END(1'b1), .OPC_W(4)) dut_e (.CLK(CLK), .RESET(RESET), .bus(bus_e));
  sap_control_sequencer #(.EARLY_END(1'b0), .OPC_W(4)) dut_f (.CLK(CLK), .RESET(RESET), .bus(bus_f));

  localparam logic [15:0] M_PC_INC   = 16'b1 << CW_PC_INC;
  localparam logic [15:0] M_PC_OE    = 16'b1 << CW_PC_OE;
  localparam logic [15:0] M_PC_LOAD  = 16'b1 << CW_PC_LOAD;
  localparam logic [15:0] M_MAR_LOAD = 16'b1 << CW_MAR_LOAD;
  localparam logic [15:0] M_RAM_OE   = 16'b1 << CW_RAM_OE;
  localparam logic [15:0] M_IR_LOAD  = 16'b1 << CW_IR_LOAD;
  localparam logic [15:0] M_IR_OE    = 16'b1 << CW_IR_OE;
  localparam logic [15:0] M_A_LOAD   = 16'b1 << CW_A_LOAD;
  localparam logic [15:0] M_B_LOAD   = 16'b1 << CW_B_LOAD;
  localparam logic [15:0] M_ALU_OE   = 16'b1 << CW_ALU_OE;
  localparam logic [15:0] M_ALU_SUB  = 16'b1 << CW_ALU_SUB;
  localparam logic [15:0] M_HLT      = 16'b1 << CW_HLT;
  localparam logic [15:0] M_DONE     = 16'b1 << CW_INSTR_DONE;

  logic [15:0] cw_e, cw_f;
  logic [4:0]  drv_e, drv_f;

  always_comb begin
    cw_e = '0;
    cw_e[CW_PC_INC] = bus_e.pc_inc;     cw_e[CW_PC_OE] = bus_e.pc_oe;
    cw_e[CW_PC_LOAD] = bus_e.pc_load;   cw_e[CW_MAR_LOAD] = bus_e.mar_load;
    cw_e[CW_RAM_OE] = bus_e.ram_oe;     cw_e[CW_RAM_WE] = bus_e.ram_we;
    cw_e[CW_IR_LOAD] = bus_e.ir_load;   cw_e[CW_IR_OE] = bus_e.ir_oe;
    cw_e[CW_A_LOAD] = bus_e.a_load;     cw_e[CW_A_OE] = bus_e.a_oe;
    cw_e[CW_B_LOAD] = bus_e.b_load;     cw_e[CW_ALU_OE] = bus_e.alu_oe;
    cw_e[CW_ALU_SUB] = bus_e.alu_sub;   cw_e[CW_OUT_LOAD] = bus_e.out_load;
    cw_e[CW_HLT] = bus_e.hlt;           cw_e[CW_INSTR_DONE] = bus_e.instr_done;
  end

  always_comb begin
    cw_f = '0;
    cw_f[CW_PC_INC] = bus_f.pc_inc;     cw_f[CW_PC_OE] = bus_f.pc_oe;
    cw_f[CW_PC_LOAD] = bus_f.pc_load;   cw_f[CW_MAR_LOAD] = bus_f.mar_load;
    cw_f[CW_RAM_OE] = bus_f.ram_oe;     cw_f[CW_RAM_WE] = bus_f.ram_we;
    cw_f[CW_IR_LOAD] = bus_f.ir_load;   cw_f[CW_IR_OE] = bus_f.ir_oe;
    cw_f[CW_A_LOAD] = bus_f.a_load;     cw_f[CW_A_OE] = bus_f.a_oe;
    cw_f[CW_B_LOAD] = bus_f.b_load;     cw_f[CW_ALU_OE] = bus_f.alu_oe;
    cw_f[CW_ALU_SUB] = bus_f.alu_sub;   cw_f[CW_OUT_LOAD] = bus_f.out_load;
    cw_f[CW_HLT] = bus_f.hlt;           cw_f[CW_INSTR_DONE] = bus_f.instr_done;
  end

  assign drv_e = {bus_e.pc_oe, bus_e.ram_oe, bus_e.ir_oe, bus_e.a_oe, bus_e.alu_oe};
  assign drv_f = {bus_f.pc_oe, bus_f.ram_oe, bus_f.ir_oe, bus_f.a_oe, bus_f.alu_oe};

  task automatic set_in(input logic r, input logic [3:0] op);
    bus_e.run = r;  bus_e.opcode = op;
    bus_f.run = r;  bus_f.opcode = op;
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    set_in(1'b1, OP_ADD);
    step();
    #1;
    checks++;
    if (bus_e.tstate !== 3'd1) begin
      failures++;
      $display("FAIL reset_tstate got=%0d want=1", bus_e.tstate);
    end
    checks++;
    if (cw_e !== 16'h0) begin
      failures++;
      $display("FAIL reset_cw got=%h want=0000", cw_e);
    end
    RESET = 1'b0;
  endtask

  task automatic test_lda();
    logic [15:0] exp_cw [5];
    exp_cw = '{M_PC_OE | M_MAR_LOAD, M_PC_INC, M_RAM_OE | M_IR_LOAD,
               M_IR_OE | M_MAR_LOAD, M_RAM_OE | M_A_LOAD | M_DONE};
    do_reset();
    set_in(1'b1, OP_LDA);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus_e.tstate !== 3'(i + 1) || cw_e !== exp_cw[i]) begin
        failures++;
        $display("FAIL lda_T%0d got t=%0d cw=%h want t=%0d cw=%h", i + 1, bus_e.tstate, cw_e, i + 1, exp_cw[i]);
      end
      step();
    end
    #1;
    checks++;
    if (bus_e.tstate !== 3'd1) begin
      failures++;
      $display("FAIL lda_wrap got=%0d want=1", bus_e.tstate);
    end
  endtask

  task automatic test_sub();
    logic [15:0] exp_cw [6];
    exp_cw = '{M_PC_OE | M_MAR_LOAD, M_PC_INC, M_RAM_OE | M_IR_LOAD, M_IR_OE | M_MAR_LOAD,
               M_RAM_OE | M_B_LOAD | M_ALU_SUB, M_ALU_OE | M_A_LOAD | M_ALU_SUB | M_DONE};
    do_reset();
    set_in(1'b1, OP_SUB);
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (bus_e.tstate !== 3'(i + 1) || cw_e !== exp_cw[i]) begin
        failures++;
        $display("FAIL sub_T%0d got t=%0d cw=%h want t=%0d cw=%h", i + 1, bus_e.tstate, cw_e, i + 1, exp_cw[i]);
      end
      step();
    end
    #1;
    checks++;
    if (bus_e.tstate !== 3'd1) begin
      failures++;
      $display("FAIL sub_wrap got=%0d want=1", bus_e.tstate);
    end
  endtask

  task automatic test_jmp_full_length();
    logic [15:0] exp_cw [6];
    exp_cw = '{M_PC_OE | M_MAR_LOAD, M_PC_INC, M_RAM_OE | M_IR_LOAD,
               M_IR_OE | M_PC_LOAD, 16'h0, M_DONE};
    do_reset();
    set_in(1'b1, OP_JMP);
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (bus_f.tstate !== 3'(i + 1) || cw_f !== exp_cw[i]) begin
        failures++;
        $display("FAIL jmp_full_T%0d got t=%0d cw=%h want t=%0d cw=%h", i + 1, bus_f.tstate, cw_f, i + 1, exp_cw[i]);
      end
      step();
    end
    #1;
    checks++;
    if (bus_f.tstate !== 3'd1) begin
      failures++;
      $display("FAIL jmp_full_wrap got=%0d want=1", bus_f.tstate);
    end
  endtask

  task automatic test_halt();
    do_reset();
    set_in(1'b1, OP_HLT);
    for (int i = 0; i < 3; i++) step();
    #1;
    checks++;
    if (bus_e.tstate !== 3'd4 || cw_e !== 16'h0) begin
      failures++;
      $display("FAIL hlt_T4 got t=%0d cw=%h want t=4 cw=0000", bus_e.tstate, cw_e);
    end
    step();
    for (int i = 0; i < 10; i++) begin
      set_in(i[0], OP_HLT);
      #1;
      checks++;
      if (bus_e.tstate !== 3'd4 || cw_e !== M_HLT) begin
        failures++;
        $display("FAIL hlt_frozen_%0d got t=%0d cw=%h want t=4 cw=%h", i, bus_e.tstate, cw_e, M_HLT);
      end
      step();
    end
    RESET = 1'b1;
    step();
    #1;
    checks++;
    if (bus_e.tstate !== 3'd1 || bus_e.hlt !== 1'b0) begin
      failures++;
      $display("FAIL hlt_reset got t=%0d hlt=%b want t=1 hlt=0", bus_e.tstate, bus_e.hlt);
    end
    RESET = 1'b0;
  endtask

  task automatic test_run_pause();
    do_reset();
    set_in(1'b1, OP_LDA);
    step();
    set_in(1'b0, OP_LDA);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus_e.tstate !== 3'd2 || cw_e !== 16'h0) begin
        failures++;
        $display("FAIL pause_%0d got t=%0d cw=%h want t=2 cw=0000", i, bus_e.tstate, cw_e);
      end
      step();
    end
    set_in(1'b1, OP_LDA);
    #1;
    checks++;
    if (bus_e.tstate !== 3'd2 || cw_e !== M_PC_INC) begin
      failures++;
      $display("FAIL pause_resume got t=%0d cw=%h want t=2 cw=%h", bus_e.tstate, cw_e, M_PC_INC);
    end
    step();
    #1;
    checks++;
    if (bus_e.tstate !== 3'd3 || cw_e !== (M_RAM_OE | M_IR_LOAD)) begin
      failures++;
      $display("FAIL pause_next got t=%0d cw=%h want t=3 cw=%h", bus_e.tstate, cw_e, M_RAM_OE | M_IR_LOAD);
    end
  endtask

  task automatic test_reset_mid_instr();
    do_reset();
    set_in(1'b1, OP_ADD);
    for (int i = 0; i < 4; i++) step();
    RESET = 1'b1;
    #1;
    checks++;
    if (bus_e.tstate !== 3'd5 || cw_e !== 16'h0) begin
      failures++;
      $display("FAIL midreset_T5 got t=%0d cw=%h want t=5 cw=0000", bus_e.tstate, cw_e);
    end
    step();
    RESET = 1'b0;
    #1;
    checks++;
    if (bus_e.tstate !== 3'd1 || cw_e !== (M_PC_OE | M_MAR_LOAD)) begin
      failures++;
      $display("FAIL midreset_T1 got t=%0d cw=%h want t=1 cw=%h", bus_e.tstate, cw_e, M_PC_OE | M_MAR_LOAD);
    end
    step();
    #1;
    checks++;
    if (bus_e.tstate !== 3'd2 || cw_e !== M_PC_INC) begin
      failures++;
      $display("FAIL midreset_T2 got t=%0d cw=%h want t=2 cw=%h", bus_e.tstate, cw_e, M_PC_INC);
    end
  endtask

  task automatic test_opcode_sweep();
    logic       unlisted;
    logic [2:0] exp_t;
    for (int op = 0; op < 16; op++) begin
      unlisted = op inside {3, 7, 8, 9, 10, 11, 12, 13};
      do_reset();
      set_in(1'b1, 4'(op));
      for (int t = 1; t <= 6; t++) begin
        exp_t = (op == 15 && t > 4) ? 3'd4 : 3'(t);
        #1;
        checks++;
        if (bus_f.tstate !== exp_t) begin
          failures++;
          $display("FAIL sweep_tstate op=%0d t=%0d got=%0d want=%0d", op, t, bus_f.tstate, exp_t);
        end
        checks++;
        if ($countones(drv_e) > 1 || $countones(drv_f) > 1) begin
          failures++;
          $display("FAIL sweep_bus op=%0d t=%0d got drivers e=%b f=%b want at most one", op, t, drv_e, drv_f);
        end
        if (unlisted && t >= 4) begin
          checks++;
          if (cw_f !== ((t == 6) ? M_DONE : 16'h0)) begin
            failures++;
            $display("FAIL sweep_nop op=%0d t=%0d got=%h want=%h", op, t, cw_f, (t == 6) ? M_DONE : 16'h0);
          end
        end
        step();
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RESET = 1'b1;
    set_in(1'b0, 4'h0);
    #2;
    test_reset();
    test_lda();
    test_sub();
    test_jmp_full_length();
    test_halt();
    test_run_pause();
    test_reset_mid_instr();
    test_opcode_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
